// File: rtl/sd_resp_pkg.sv
// sd_resp_pkg: shared state encoding and sector constants for the sector responder
package sd_resp_pkg;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_CAP, WR_REQ, FINISH} state_t;
    localparam int SECTOR_BYTES = 512;
    localparam logic [8:0] LAST_BYTE = 9'd511;
endpackage

// File: rtl/sd_resp_store_if.sv
// sd_resp_store_if: holds one store request until acknowledged and captures read data
module sd_resp_store_if #(
    parameter int AW = 15
) (
    input  logic          clk_sys,
    input  logic          RESET_n,
    input  logic          rd_start,
    input  logic          wr_start,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [AW-1:0] st_addr,
    output logic          st_rd,
    output logic          st_wr,
    output logic [7:0]    st_dout,
    input  logic [7:0]    st_din,
    input  logic          st_ack,
    output logic [7:0]    rdata,
    output logic          done
);
    assign done = st_ack & (st_rd | st_wr);

    // launch a request on start, drop it on ack, keep the byte returned by a read
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            st_addr <= '0;
            st_rd   <= 1'b0;
            st_wr   <= 1'b0;
            st_dout <= 8'h00;
            rdata   <= 8'h00;
        end else begin
            if (rd_start | wr_start) begin
                st_addr <= addr;
                st_rd   <= rd_start;
                st_wr   <= wr_start;
                if (wr_start) st_dout <= wdata;
            end else if (done) begin
                st_rd <= 1'b0;
                st_wr <= 1'b0;
            end
            if (st_rd & st_ack) rdata <= st_din;
        end
    end
endmodule

// File: rtl/sd_sector_responder.sv
// sd_sector_responder: serves 512-byte sd_* sector transfers from a byte-wide backing store
module sd_sector_responder
    import sd_resp_pkg::*;
#(
    parameter int LBA_W = 6,
    localparam int ST_AW = LBA_W + 9
) (
    input  logic             clk_sys,
    input  logic             RESET_n,
    input  logic [31:0]      sd_lba,
    input  logic             sd_rd,
    input  logic             sd_wr,
    output logic             sd_ack,
    output logic [8:0]       sd_buff_addr,
    output logic [7:0]       sd_buff_dout,
    output logic             sd_buff_wr,
    input  logic [7:0]       sd_buff_din,
    output logic [ST_AW-1:0] st_addr,
    output logic             st_rd,
    output logic             st_wr,
    output logic [7:0]       st_dout,
    input  logic [7:0]       st_din,
    input  logic             st_ack,
    output logic             busy,
    output logic             err
);
    state_t           state;
    logic [LBA_W-1:0] lba;
    logic [8:0]       cnt;
    logic             oob;
    logic             in_range;
    logic             rd_start;
    logic             wr_start;
    logic             done;
    logic [ST_AW-1:0] req_addr;
    logic [7:0]       rdata;

    // out-of-range sectors never touch the store but keep the normal byte cadence
    assign in_range     = ~|sd_lba[31:LBA_W];
    assign rd_start     = (state == IDLE && sd_rd && in_range) || (state == RD_PUT && cnt != LAST_BYTE && !oob);
    assign wr_start     = state == WR_CAP && !oob;
    assign req_addr     = state == IDLE ? {sd_lba[LBA_W-1:0], 9'd0} : state == RD_PUT ? {lba, cnt + 9'd1} : {lba, cnt};
    assign sd_buff_dout = oob ? 8'h00 : rdata;
    assign busy         = state != IDLE;

    sd_resp_store_if #(.AW(ST_AW)) u_store (
        .clk_sys (clk_sys),
        .RESET_n (RESET_n),
        .rd_start(rd_start),
        .wr_start(wr_start),
        .addr    (req_addr),
        .wdata   (sd_buff_din),
        .st_addr (st_addr),
        .st_rd   (st_rd),
        .st_wr   (st_wr),
        .st_dout (st_dout),
        .st_din  (st_din),
        .st_ack  (st_ack),
        .rdata   (rdata),
        .done    (done)
    );

    // transfer sequencer: accepts a request in IDLE and walks the 512 bytes of the sector
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state        <= IDLE;
            lba          <= '0;
            cnt          <= 9'd0;
            oob          <= 1'b0;
            err          <= 1'b0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= 9'd0;
            sd_buff_wr   <= 1'b0;
        end else begin
            err        <= 1'b0;
            sd_buff_wr <= 1'b0;
            case (state)
                IDLE: if (sd_rd | sd_wr) begin
                    lba    <= sd_lba[LBA_W-1:0];
                    oob    <= !in_range;
                    err    <= !in_range;
                    cnt    <= 9'd0;
                    sd_ack <= 1'b1;
                    if (!sd_rd) sd_buff_addr <= 9'd0;
                    state  <= sd_rd ? RD_REQ : WR_ADDR;
                end
                RD_REQ: if (oob || done) begin
                    sd_buff_addr <= cnt;
                    sd_buff_wr   <= 1'b1;
                    state        <= RD_PUT;
                end
                RD_PUT: if (cnt == LAST_BYTE) begin
                    sd_ack <= 1'b0;
                    state  <= FINISH;
                end else begin
                    cnt   <= cnt + 9'd1;
                    state <= RD_REQ;
                end
                WR_ADDR: state <= WR_CAP;
                WR_CAP:  state <= WR_REQ;
                WR_REQ: if (oob || done) begin
                    if (cnt == LAST_BYTE) begin
                        sd_ack <= 1'b0;
                        state  <= FINISH;
                    end else begin
                        cnt          <= cnt + 9'd1;
                        sd_buff_addr <= cnt + 9'd1;
                        state        <= WR_ADDR;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sd_sector_responder.md
Name: sd_sector_responder

Overview:
- Target (responder) end of the sector handshake the core uses for backup-RAM load/save: sd_lba / sd_rd / sd_wr in, sd_ack / sd_buff_* out.
- Serves 512-byte sectors from a byte-wide backing store (BRAM or SDRAM port) instead of the HPS.
- Used as the synthesizable save-store back end and as the bench model for save/load logic.

Parameters:
LBA_W, 6, sector-number width; store holds 2^LBA_W sectors (default 32 KiB).
ST_AW, LBA_W+9, backing-store byte address width (derived; do not override).

Ports:
clk_sys  in  1  system clock
RESET_n  in  1  asynchronous, active-low reset
sd_lba  in  32  sector number, sampled when a request is accepted
sd_rd  in  1  read request (store -> initiator buffer), level
sd_wr  in  1  write request (initiator buffer -> store), level
sd_ack  out  1  high for the whole transfer
sd_buff_addr  out  9  byte index within sector
sd_buff_dout  out  8  read data to initiator buffer
sd_buff_wr  out  1  one-cycle write strobe for sd_buff_dout
sd_buff_din  in  8  initiator buffer data; valid one cycle after sd_buff_addr changes (registered RAM)
st_addr  out  ST_AW  store byte address = {lba[LBA_W-1:0], byte index}
st_rd  out  1  store read request; held until st_ack
st_wr  out  1  store write request; held until st_ack
st_dout  out  8  store write data
st_din  in  8  store read data, valid in the st_ack cycle
st_ack  in  1  store completion; may be asserted in the first request cycle
busy  out  1  state != IDLE
err  out  1  one-cycle pulse at the start of an out-of-range request

Behaviour:
- Reset (async, RESET_n=0): state=IDLE; all outputs 0, including counters and the latched lba.
- States: IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_CAP, WR_REQ, FINISH.
- IDLE: when sd_rd|sd_wr is sampled high:
  - latch sd_lba and direction; byte counter=0; sd_ack=1 from the next cycle.
  - sd_rd has priority if both are high.
  - Go to RD_REQ or WR_ADDR.
- Request ownership: the initiator must drop sd_rd/sd_wr on the sd_ack rising edge. A request still high when FINISH returns to IDLE starts a new transfer.
- Range check: out of range if sd_lba >= 2^LBA_W, i.e. any bit of sd_lba[31:LBA_W] is set.
  - err pulses in the first ack cycle.
  - st_rd and st_wr stay 0 for the whole transfer; RD_REQ and WR_REQ each last exactly one cycle.
  - Reads deliver 0x00. Writes are discarded.
  - The byte cadence is otherwise unchanged.
- Read path:
  - RD_REQ: st_addr={lba,cnt}; st_rd=1 until st_ack; capture st_din in the st_ack cycle; go to RD_PUT.
  - RD_PUT: sd_buff_addr=cnt; sd_buff_dout=captured byte; sd_buff_wr=1 for exactly one cycle.
    - cnt==511: go to FINISH.
    - Otherwise: cnt+1, back to RD_REQ.
  - Minimum 2 cycles/byte.
- Write path:
  - WR_ADDR: sd_buff_addr=cnt.
  - WR_CAP: capture sd_buff_din into st_dout.
  - WR_REQ: st_addr={lba,cnt}; st_wr=1 until st_ack.
    - Then cnt==511: go to FINISH.
    - Otherwise: cnt+1, back to WR_ADDR.
  - Minimum 3 cycles/byte.
- sd_buff_addr changes only in RD_PUT/WR_ADDR and is held stable otherwise. sd_buff_wr is never high in write mode.
- FINISH: sd_ack=0, sd_buff_wr=0; go to IDLE the next cycle.
  - Minimum read transfer: ack high 1024 cycles.
  - Minimum write transfer: ack high 1536 cycles.
- cnt is 9 bits; the terminal test is cnt==511. There is no wrap into the next sector.
- Requests arriving while busy are ignored: sampled only in IDLE.
- sd_lba changes mid-transfer have no effect.
- st_ack outside st_rd/st_wr is ignored.
- Reset mid-transfer: immediate return to IDLE with outputs 0. A store write already acknowledged stays committed; nothing else does.

Decomposition:
- Shared package sd_resp_pkg:
  - state enum;
  - localparams SECTOR_BYTES=512 and LAST_BYTE=9'd511.
- One natural sub-module, sd_resp_store_if: the st_* request/ack holder (holds the request until ack, captures read data). It is reused on SDRAM-backed builds.

Test Plan:
- Read sector 3, store byte = addr[7:0]^8'hA5, st_ack immediate → 512 sd_buff_wr pulses; addr 0..511 with dout = ({3,idx}[7:0])^A5; sd_ack high exactly 1024 cycles; err=0.
- Write sector 5, initiator buffer = idx[7:0] → store bytes 0xA00..0xBFF hold 0x00..0xFF; no sd_buff_wr; ack high 1536 cycles.
- Initiator loop as in the save path: lba 0..63, rd reissued on each ack fall → 64 complete transfers, no missed or duplicated sector.
- sd_lba=64 read → err one pulse; st_rd never asserted; all 512 dout=0x00. sd_lba=64 write → store unchanged.
- st_ack delayed 3 cycles per byte → st_rd held 4 cycles each; data correct; sd_buff_addr stable during stalls.
- sd_rd and sd_wr high together → read performed. RESET_n low at byte 200 → sd_ack=0, busy=0 immediately; the next request completes normally.
